// File: rtl/int_to_posit_slave.sv
// AXI-Stream slave: signed N-bit integers -> PS-bit posits (ES=0), buffered in a D-entry FIFO with a req/ack read port.
// Optional macro FIFO_LEVEL_EN adds the fifo_level output (registered entry count).
module int_to_posit_slave #(
    parameter int N   = 8,
    parameter int PS  = 16,
    parameter int ES  = 0,
    parameter int D   = 256,
    parameter int D_S = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_axis_tvalid,
    input  logic [N-1:0]  rx_axis_tdata,
    output logic          rx_axis_tready,
    input  logic          pipe_read_req,
    output logic [PS-1:0] pipe_read_data,
    output logic          pipe_read_ack,
    output logic          pipe_read_empty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [D_S:0]  fifo_level
`endif
);

    if (ES != 0) begin : g_es_check
        $error("int_to_posit_slave supports only ES = 0");
    end

    // Builds the posit MSB-first: sign 0, regime ones, regime terminator, then the
    // magnitude bits below the leading one; negatives are the two's complement.
    function automatic logic [PS-1:0] to_posit(input logic [N-1:0] x);
        logic signed [N:0] xe;
        logic [N:0]        mag;
        logic [PS-1:0]     pos;
        logic              bitv;
        int                lead;
        int                sh;
        xe   = {x[N-1], x};
        mag  = x[N-1] ? -xe : xe;
        lead = 0;
        for (int i = 0; i <= N; i++) begin
            if (((mag >> i) & (N+1)'(1)) != '0) lead = i;
        end
        pos = '0;
        for (int i = 0; i < PS-1; i++) begin
            bitv = 1'b0;
            if (i <= lead) begin
                bitv = 1'b1;
            end else if (i > lead + 1) begin
                sh = 2 * lead + 1 - i;
                if (sh >= 0) bitv = ((mag >> sh) & (N+1)'(1)) != '0;
            end
            pos = {pos[PS-2:0], bitv};
        end
        if (x == '0)        return '0;
        else if (x[N-1])    return -pos;
        else                return pos;
    endfunction

    logic [PS-1:0]  mem [D];
    logic [D_S-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [D_S:0]   count_reg, count_next;
    logic           stage_valid_reg;
    logic [N-1:0]   stage_data_reg;
    logic           tready_reg, tready_next;
    logic           ack_reg, empty_reg;
    logic [PS-1:0]  read_data_reg;
    logic [PS-1:0]  conv_posit;
    logic           accept, do_write, do_read;

    assign accept     = rx_axis_tvalid & tready_reg;
    assign do_write   = stage_valid_reg;
    assign do_read    = pipe_read_req & (count_reg != '0);
    assign conv_posit = to_posit(stage_data_reg);

    always_comb begin
        count_next = count_reg;
        if (do_write && !do_read)
            count_next = count_reg + (D_S+1)'(1);
        else if (!do_write && do_read)
            count_next = count_reg - (D_S+1)'(1);
    end

    // The beat in the convert stage counts against capacity so a full FIFO never drops it.
    assign tready_next = ({1'b0, count_next} + (D_S+2)'(accept)) < (D_S+2)'(D);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            stage_valid_reg <= 1'b0;
            stage_data_reg  <= '0;
            tready_reg      <= 1'b0;
            empty_reg       <= 1'b1;
        end else begin
            stage_valid_reg <= accept;
            if (accept) stage_data_reg <= rx_axis_tdata;
            if (do_write) wr_ptr_reg <= wr_ptr_reg + (D_S)'(1);
            if (do_read)  rd_ptr_reg <= rd_ptr_reg + (D_S)'(1);
            count_reg  <= count_next;
            tready_reg <= tready_next;
            empty_reg  <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) mem[wr_ptr_reg] <= conv_posit;
    end

    // Registered read port; data holds between successful reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_reg <= '0;
            ack_reg       <= 1'b0;
        end else begin
            ack_reg <= do_read;
            if (do_read) read_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign rx_axis_tready  = tready_reg;
    assign pipe_read_data  = read_data_reg;
    assign pipe_read_ack   = ack_reg;
    assign pipe_read_empty = empty_reg;
`ifdef FIFO_LEVEL_EN
    assign fifo_level      = count_reg;
`endif

endmodule

// File: tb/tb_int_to_posit_slave.sv
// Self-checking bench for int_to_posit_slave: directed vector table, corner sequences and random traffic vs a queue model.
module tb_int_to_posit_slave;
    localparam int N = 8, PS = 16, D = 256, D_S = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_axis_tvalid = 1'b0;
    logic [N-1:0]  rx_axis_tdata = '0;
    logic          rx_axis_tready;
    logic          pipe_read_req = 1'b0;
    logic [PS-1:0] pipe_read_data;
    logic          pipe_read_ack;
    logic          pipe_read_empty;
`ifdef FIFO_LEVEL_EN
    logic [D_S:0]  fifo_level;
`endif

    int_to_posit_slave #(.N(N), .PS(PS), .ES(0), .D(D), .D_S(D_S)) dut (
        .clk(clk),
        .reset(reset),
        .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tdata(rx_axis_tdata),
        .rx_axis_tready(rx_axis_tready),
        .pipe_read_req(pipe_read_req),
        .pipe_read_data(pipe_read_data),
        .pipe_read_ack(pipe_read_ack),
        .pipe_read_empty(pipe_read_empty)
`ifdef FIFO_LEVEL_EN
        ,
        .fifo_level(fifo_level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [PS-1:0] posit; int acc_edge; } entry_t;
    typedef struct { logic [N-1:0] x; logic [PS-1:0] expv; } vec_t;

    entry_t        sb[$];
    logic [PS-1:0] rx_log[$];
    logic [PS-1:0] last_data = '0;
    int            n_cmp = 0, n_fail = 0;
    int            edge_no = 0, last_acc_edge = -1, last_ack_edge = -1;
    bit            tready_dropped = 0;

    // Posit value from the arithmetic definition: |x| = 2^k * (1 + f/2^k).
    function automatic logic [PS-1:0] ref_posit(input int x);
        int m, k, f, p;
        if (x == 0) return '0;
        m = (x < 0) ? -x : x;
        k = 0;
        while ((1 << (k + 1)) <= m) k++;
        f = m - (1 << k);
        p = ((1 << (k + 1)) - 1) << (PS - 2 - k);
        p = p | ((f << (PS - 3 - k)) >> k);
        if (x < 0) p = (1 << PS) - p;
        return PS'(p);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, expv);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare every output.
    task automatic tick();
        bit            acc, req_pre, rst_pre, exp_ack;
        logic [N-1:0]  d_pre;
        int            written;
        rst_pre = reset;
        acc     = rx_axis_tvalid && rx_axis_tready;
        req_pre = pipe_read_req;
        d_pre   = rx_axis_tdata;
        @(posedge clk);
        edge_no++;
        #1;
        if (rst_pre) begin
            sb.delete();
            last_data = '0;
            check("rst_tready", int'(rx_axis_tready), 0);
            check("rst_ack", int'(pipe_read_ack), 0);
            check("rst_empty", int'(pipe_read_empty), 1);
            check("rst_data", int'(pipe_read_data), 0);
            return;
        end
        exp_ack = req_pre && (sb.size() > 0) && (sb[0].acc_edge + 2 <= edge_no);
        if (exp_ack) begin
            last_data = sb[0].posit;
            void'(sb.pop_front());
        end
        if (acc) begin
            sb.push_back('{ref_posit(int'($signed(d_pre))), edge_no});
            last_acc_edge = edge_no;
        end
        if (pipe_read_ack) begin
            rx_log.push_back(pipe_read_data);
            last_ack_edge = edge_no;
        end
        written = 0;
        foreach (sb[i]) if (sb[i].acc_edge + 1 <= edge_no) written++;
        check("ack", int'(pipe_read_ack), int'(exp_ack));
        check("data", int'(pipe_read_data), int'(last_data));
        check("empty", int'(pipe_read_empty), int'(written == 0));
        check("tready", int'(rx_axis_tready), int'(sb.size() < D));
`ifdef FIFO_LEVEL_EN
        check("fifo_level", int'(fifo_level), written);
`endif
        if (!rx_axis_tready) tready_dropped = 1;
    endtask

    task automatic send(input logic [N-1:0] x);
        bit done = 0;
        rx_axis_tdata  = x;
        rx_axis_tvalid = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (rx_axis_tready) done = 1;
            tick();
        end
        if (!done) check("send_timeout", 0, 1);
        rx_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        pipe_read_req = 1'b1;
        for (int t = 0; t < 2000 && !done; t++) begin
            if (sb.size() == 0) done = 1;
            else tick();
        end
        pipe_read_req = 1'b0;
        tick();
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        logic [N-1:0] beat257;
        int cnt;
        bit got;

        tbl[0] = '{8'sd0,    16'h0000};
        tbl[1] = '{8'sd1,    16'h4000};
        tbl[2] = '{8'sd2,    16'h6000};
        tbl[3] = '{8'sd3,    16'h6800};
        tbl[4] = '{-8'sd1,   16'hC000};
        tbl[5] = '{8'sd127,  16'h7F7E};
        tbl[6] = '{-8'sd128, 16'h8080};
        tbl[7] = '{8'sd5,    16'h7200};

        // Reset for three cycles, then release.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("post_reset_tready", int'(rx_axis_tready), 1);
        check("post_reset_empty", int'(pipe_read_empty), 1);

        // Directed vector table, streamed back to back then read out.
        rx_log.delete();
        for (int i = 0; i < 8; i++) send(tbl[i].x);
        repeat (2) tick();
        pipe_read_req = 1'b1;
        repeat (8) tick();
        pipe_read_req = 1'b0;
        tick();
        check("tbl_count", rx_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < rx_log.size()) check($sformatf("tbl_%0d", i), int'(rx_log[i]), int'(tbl[i].expv));

        // Fill to capacity; beat 257 must wait and not be lost.
        for (int b = 0; b < 256; b++) send(N'($urandom));
        tick();
        check("full_tready", int'(rx_axis_tready), 0);
        beat257 = 8'h9C;
        rx_axis_tdata  = beat257;
        rx_axis_tvalid = 1'b1;
        repeat (5) tick();
        check("full_held", sb.size(), 256);
        pipe_read_req = 1'b1;
        tick();
        pipe_read_req = 1'b0;
        send(beat257);
        rx_log.delete();
        drain();
        check("beat257_count", rx_log.size(), 256);
        if (rx_log.size() > 0)
            check("beat257_data", int'(rx_log[rx_log.size()-1]), int'(ref_posit(int'($signed(beat257)))));

        // Request on empty, then single sample latency.
        pipe_read_req = 1'b1;
        tick();
        check("empty_req_no_ack", int'(pipe_read_ack), 0);
        send(8'd5);
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (pipe_read_ack) got = 1;
        end
        pipe_read_req = 1'b0;
        check("lat_ack_seen", int'(got), 1);
        check("lat_edges", last_ack_edge - last_acc_edge, 2);
        check("lat_data", int'(pipe_read_data), 16'h7200);
        tick();

        // Long stream with concurrent reads: pointers wrap, tready stays high.
        tready_dropped = 0;
        cnt = 0;
        rx_log.delete();
        pipe_read_req  = 1'b1;
        rx_axis_tvalid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            rx_axis_tdata = N'($urandom);
            if (rx_axis_tready) cnt++;
            tick();
        end
        rx_axis_tvalid = 1'b0;
        drain();
        check("stream_accepted", cnt, 1000);
        check("stream_read", rx_log.size(), 1000);
        check("stream_tready_high", int'(tready_dropped), 0);

        // Reset with data buffered discards everything.
        for (int b = 0; b < 10; b++) send(N'($urandom));
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_flush_empty", int'(pipe_read_empty), 1);
        pipe_read_req = 1'b1;
        tick();
        pipe_read_req = 1'b0;
        check("rst_flush_no_ack", int'(pipe_read_ack), 0);

        // Random traffic.
        for (int t = 0; t < 3000; t++) begin
            rx_axis_tvalid = 1'($urandom_range(0, 1));
            rx_axis_tdata  = N'($urandom);
            pipe_read_req  = ($urandom_range(0, 2) != 0);
            tick();
        end
        rx_axis_tvalid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
